onehot_key_debouncer: RTL

- Upstream stage of the 8-to-3 priority-free encoder; converts 8 raw, bouncy, asynchronous key/switch lines into a clean registered one-hot vector.
- Output is only ever all-zero or exactly one bit set, so the downstream encoder's Good flag and 3-bit code are always meaningful.
- Simultaneous presses are rejected and flagged rather than passed through.

---
 rtl/onehot_key_debouncer.sv | 117 +++++++++++
 1 files changed

// File: rtl/onehot_key_debouncer.sv
// Turns 8 raw, bouncy key lines into a clean registered one-hot code.
// Simultaneous presses are rejected and flagged instead of being passed on.
module onehot_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_raw,
  output logic [7:0] key_onehot,
  output logic       key_valid,
  output logic       key_strobe,
  output logic       multi_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    MULTI = 2'd2
  } state_t;

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       stable;
  logic [CNT_W-1:0] cnt [8];
  state_t           state;
  logic             stable_one;
  logic             stable_many;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // A bit's debounced value flips only after a full run of consecutive disagreements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign stable_one  = (stable != 8'h00) && ((stable & (stable - 8'd1)) == 8'h00);
  assign stable_many = (stable != 8'h00) && !stable_one;

  // In HELD, key_onehot doubles as the latched code being compared against.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      key_onehot <= 8'h00;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
      multi_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (stable_one) begin
            state      <= HELD;
            key_onehot <= stable;
            key_valid  <= 1'b1;
            key_strobe <= 1'b1;
          end else if (stable_many) begin
            state     <= MULTI;
            multi_err <= 1'b1;
          end
        end
        HELD: begin
          if (stable == 8'h00) begin
            state      <= IDLE;
            key_onehot <= 8'h00;
            key_valid  <= 1'b0;
          end else if (stable != key_onehot) begin
            state      <= MULTI;
            key_onehot <= 8'h00;
            key_valid  <= 1'b0;
            multi_err  <= 1'b1;
          end
        end
        MULTI: begin
          if (stable == 8'h00) begin
            state     <= IDLE;
            multi_err <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          key_onehot <= 8'h00;
          key_valid  <= 1'b0;
          multi_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
